// File: rtl/layer_stream_source_if.sv
// Stream handshake bundle between layer_stream_source and a layer input.
// Signals: m_valid, m_ready, data_out; master drives valid/data, slave ready.
interface layer_stream_source_if #(
  parameter int T = 16
);
  logic         m_valid;
  logic         m_ready;
  logic [T-1:0] data_out;

  modport master (
    output m_valid,
    output data_out,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  data_out,
    output m_ready
  );
endinterface

// File: rtl/layer_stream_source.sv
// Buffered word source: load over wr_* port, on start stream num_vals words.
// Ports: clk, reset (async, active-low), wr_en/wr_addr/wr_data buffer write,
// start/num_vals run request, busy/done status, stream (master) handshake.
// Option: define THROTTLE_LFSR_EN to gate word loads with a 16-bit LFSR.
module layer_stream_source #(
  parameter  int T     = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          start,
  input  logic [AW:0]   num_vals,
  output logic          busy,
  output logic          done,
  layer_stream_source_if.master stream
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

  state_t      state, state_nx;
  logic [T-1:0] mem [DEPTH];
  logic [AW:0] rd_ptr;
  logic [AW:0] sent;
  logic [AW:0] total;
  logic [AW:0] sent_inc;
  logic [AW:0] nv;
  logic        hs;
  logic        last;
  logic        go;
  logic        zero;
  logic        gate;
  logic        load;

`ifdef THROTTLE_LFSR_EN
  logic [15:0] lfsr;

  // Taps 16,14,13,11 in right-shifting Fibonacci form.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
               lfsr[15:1]};
    end
  end

  assign gate = lfsr[0];
`else
  assign gate = 1'b1;
`endif

  assign nv       = (num_vals > DMAX) ? DMAX : num_vals;
  assign hs       = stream.m_valid & stream.m_ready;
  assign sent_inc = sent + 1'b1;
  assign last     = hs & (sent_inc == total);
  assign go       = (state == IDLE) & start & (nv != '0);
  assign zero     = (state == IDLE) & start & (nv == '0);

  // Refill the output register when it is empty or being consumed.
  assign load = (state == STREAM)
              & (~stream.m_valid | stream.m_ready)
              & (rd_ptr < total)
              & gate;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (go)   state_nx = STREAM;
      STREAM: if (last) state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream.m_valid  <= 1'b0;
      stream.data_out <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_ptr          <= '0;
      sent            <= '0;
      total           <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        busy   <= 1'b1;
        total  <= nv;
        rd_ptr <= '0;
        sent   <= '0;
      end
      if (zero) begin
        done <= 1'b1;
      end
      if (hs) begin
        sent <= sent_inc;
      end
      if (load) begin
        stream.data_out <= mem[rd_ptr[AW-1:0]];
        stream.m_valid  <= 1'b1;
        rd_ptr          <= rd_ptr + 1'b1;
      end else if (hs) begin
        stream.m_valid <= 1'b0;
      end
      if (last) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        rd_ptr <= '0;
        sent   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_stream_source.sv
// Directed bench for layer_stream_source: ordering, flow control, clamp,
// zero-length runs, mid-stream reset and writes/starts ignored while busy.
module tb_layer_stream_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [4:0]  num_vals;
  logic        busy;
  logic        done;

  layer_stream_source_if #(.T(16)) sif ();

  layer_stream_source #(.T(16), .DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .num_vals (num_vals),
    .busy     (busy),
    .done     (done),
    .stream   (sif)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] got_q [$];
  int          first_v;
  int          last_hs;
  int          done_idx;
  int          done_cnt;
  int          busy_seen;
  int          valid_seen;
  int          k;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic write_word(input logic [3:0] a,
                            input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic write_end();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [4:0] n,
                     input bit tog,
                     input bit inject);
    logic        held;
    logic [15:0] held_d;
    held   = 1'b0;
    held_d = '0;
    got_q.delete();
    first_v    = -1;
    last_hs    = -1;
    done_idx   = -1;
    done_cnt   = 0;
    busy_seen  = 0;
    valid_seen = 0;
    @(negedge clk);
    start    = 1'b1;
    num_vals = n;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (inject && i == 1) begin
        wr_en    = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = 16'h0099;
        start    = 1'b1;
        num_vals = 5'd2;
      end
      sif.m_ready = tog ? (i % 2 == 0) : 1'b1;
      if (held) begin
        check("hold_valid", 32'(sif.m_valid), 32'd1);
        check("hold_data", 32'(sif.data_out), 32'(held_d));
      end
      if (busy) busy_seen++;
      if (sif.m_valid) begin
        valid_seen++;
        if (first_v < 0) first_v = i;
      end
      if (sif.m_valid && sif.m_ready) begin
        got_q.push_back(sif.data_out);
        last_hs = i;
      end
      held   = sif.m_valid && !sif.m_ready;
      held_d = sif.data_out;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx >= 0 && i >= done_idx + 2) break;
    end
    check("done_seen", 32'(done_idx >= 0), 32'd1);
    sif.m_ready = 1'b1;
  endtask

  task automatic check_seq(input string tag,
                           input int n,
                           input logic [15:0] base);
    logic [15:0] w;
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      w = (j < got_q.size()) ? got_q[j] : 16'hxxxx;
      check({tag, "_word"}, 32'(w), 32'(base + 16'(j)));
    end
  endtask

  initial begin
    reset       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    start       = 1'b0;
    num_vals    = '0;
    sif.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(sif.m_valid), 32'd0);
    check("rst_data", 32'(sif.data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++)
      write_word(4'(i), 16'(i + 1));
    write_end();

    run(5'd4, 1'b0, 1'b0);
    check_seq("t1", 4, 16'd1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
`ifndef THROTTLE_LFSR_EN
    check("t1_first_valid", 32'(first_v), 32'd1);
    check("t1_last_hs", 32'(last_hs), 32'd4);
    check("t1_done_idx", 32'(done_idx), 32'd5);
`endif
    check("t1_busy_end", 32'(busy), 32'd0);

    run(5'd4, 1'b1, 1'b0);
    check_seq("t2", 4, 16'd1);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    run(5'd0, 1'b0, 1'b0);
    check("t3_valid_seen", 32'(valid_seen), 32'd0);
    check("t3_busy_seen", 32'(busy_seen), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_done_idx", 32'(done_idx), 32'd0);

    for (int i = 0; i < 16; i++)
      write_word(4'(i), 16'hFFF0 + 16'(i));
    write_end();
    run(5'd21, 1'b0, 1'b0);
    check_seq("t4", 16, 16'hFFF0);
    check("t4_last_word", 32'(got_q[$]), 32'h0000FFFF);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 4; i++)
      write_word(4'(i), 16'(i + 1));
    write_end();

    @(negedge clk);
    start       = 1'b1;
    num_vals    = 5'd4;
    sif.m_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (sif.m_valid && sif.m_ready) k++;
      if (k == 2) break;
    end
    check("t5_hs2_reached", 32'(k), 32'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(sif.m_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data", 32'(sif.data_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run(5'd4, 1'b0, 1'b0);
    check_seq("t5", 4, 16'd1);

    run(5'd4, 1'b0, 1'b1);
    check_seq("t6", 4, 16'd1);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    run(5'd1, 1'b0, 1'b0);
    check_seq("t6_mem0", 1, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
